x_stream_loader: RTL and testbench

- Synthesizable feeder directly upstream of top_top_test.
- Reads 7-bit X samples from a synchronous ROM/SRAM holding MATRIX_NUM matrices of WORDS_PER_MATRIX words each.
- Streams each matrix to the compute core with a start pulse and a valid-qualified burst, then waits for the core's finish before sending the next matrix.
- Replaces the bench-only stimulus FSM so the datapath can be driven on silicon and FPGA.

---
 rtl/x_loader_pkg.sv | 18 +
 rtl/x_rd_pipe.sv | 38 +++
 rtl/x_stream_loader.sv | 117 +++++++++++
 tb/tb_x_stream_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/x_loader_pkg.sv
// x_loader_pkg: shared FSM encoding and datapath defaults for the X stream feeder
package x_loader_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ISSUE    = 2'd1;
    localparam logic [1:0] WAIT_FIN = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    // Defaults shared with the compute core
    localparam int WORDS_PER_MATRIX_DEF = 32;
    localparam int DATA_W_DEF           = 7;

    // Counter width that stays legal when the count range collapses to one value
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/x_rd_pipe.sv
// x_rd_pipe: one-stage register aligning synchronous-memory read data with its valid flag
module x_rd_pipe
    import x_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_vld,
    input  logic [DATA_W-1:0] rd_data,
    output logic              valid_out,
    output logic [DATA_W-1:0] x_out
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] x_q, x_d;

    // Capture data only on valid beats so x_out holds between bursts
    always_comb begin
        valid_d = rd_vld;
        x_d     = rd_vld ? rd_data : x_q;
    end

    // Output stage registers, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            x_q     <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
        end
    end

    assign valid_out = valid_q;
    assign x_out     = x_q;

endmodule

// File: rtl/x_stream_loader.sv
// x_stream_loader: streams MATRIX_NUM matrices from a synchronous ROM to the compute core
module x_stream_loader
    import x_loader_pkg::*;
#(
    parameter int MATRIX_NUM       = 2,
    parameter int WORDS_PER_MATRIX = WORDS_PER_MATRIX_DEF,
    parameter int DATA_W           = DATA_W_DEF,
    parameter int ADDR_W           = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              start_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] x_out,
    input  logic              finish_in,
    output logic              busy,
    output logic              done
);

    localparam int MI_W = cnt_w(MATRIX_NUM);
    localparam int WC_W = cnt_w(WORDS_PER_MATRIX);
    localparam logic [MI_W-1:0] LAST_MAT  = MI_W'(MATRIX_NUM - 1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_MATRIX - 1);

    logic [1:0]        state_q, state_d;
    logic [MI_W-1:0]   matrix_idx_q, matrix_idx_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic              fin_seen_q, fin_seen_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              start_q, start_d;
    logic              rd_vld_q, rd_vld_d;
    logic              done_q, done_d;
    logic              pipe_empty;
    logic              last_word;
    logic              last_mat;

    assign pipe_empty = !rd_vld_q && !valid_out;
    assign last_word  = (word_cnt_q == LAST_WORD);
    assign last_mat   = (matrix_idx_q == LAST_MAT);

    // Sequencer: issue a full matrix, then hold until the core finishes and the pipe drains
    always_comb begin
        state_d      = state_q;
        matrix_idx_d = matrix_idx_q;
        word_cnt_d   = word_cnt_q;
        case (state_q)
            IDLE: state_d = go ? ISSUE : IDLE;
            ISSUE: begin
                word_cnt_d = last_word ? '0 : word_cnt_q + WC_W'(1);
                state_d    = last_word ? WAIT_FIN : ISSUE;
            end
            WAIT_FIN: begin
                if ((fin_seen_q || finish_in) && pipe_empty) begin
                    state_d      = last_mat ? DONE : ISSUE;
                    matrix_idx_d = last_mat ? matrix_idx_q : matrix_idx_q + MI_W'(1);
                end
            end
            DONE: begin
                state_d      = IDLE;
                matrix_idx_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs; the address is precomputed so it is valid in the cycle it is issued
    always_comb begin
        start_d    = (state_d == ISSUE) && (state_q != ISSUE);
        rd_vld_d   = (state_q == ISSUE);
        done_d     = (state_d == DONE);
        fin_seen_d = start_d ? 1'b0 : ((state_q == WAIT_FIN) && finish_in) ? 1'b1 : fin_seen_q;
        rom_addr_d = ADDR_W'(int'(matrix_idx_d) * WORDS_PER_MATRIX + int'(word_cnt_d));
    end

    // Control state registers, all cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            matrix_idx_q <= '0;
            word_cnt_q   <= '0;
            fin_seen_q   <= 1'b0;
            rom_addr_q   <= '0;
            start_q      <= 1'b0;
            rd_vld_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            matrix_idx_q <= matrix_idx_d;
            word_cnt_q   <= word_cnt_d;
            fin_seen_q   <= fin_seen_d;
            rom_addr_q   <= rom_addr_d;
            start_q      <= start_d;
            rd_vld_q     <= rd_vld_d;
            done_q       <= done_d;
        end
    end

    x_rd_pipe #(
        .DATA_W(DATA_W)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .rd_vld   (rd_vld_q),
        .rd_data  (rom_rdata),
        .valid_out(valid_out),
        .x_out    (x_out)
    );

    assign rom_addr  = rom_addr_q;
    assign start_out = start_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_x_stream_loader.sv
// tb_x_stream_loader: randomized run-level checks of the X stream feeder against a timing/data model
module tb_x_stream_loader;

    localparam int W  = 32;
    localparam int M  = 2;
    localparam int DW = 7;
    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, go, finish_in, start_out, valid_out, busy, done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rdata, x_out;
    logic          go1, fin1, start1, valid1, busy1, done1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] rdata1, x1;

    logic [DW-1:0] mem [64];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_q[$];
    int beat_c[$];
    int done_q[$];
    logic [DW-1:0] beat_v[$];

    x_stream_loader #(.MATRIX_NUM(M), .WORDS_PER_MATRIX(W), .DATA_W(DW), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .go(go), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .start_out(start_out), .valid_out(valid_out), .x_out(x_out),
        .finish_in(finish_in), .busy(busy), .done(done));

    x_stream_loader #(.MATRIX_NUM(1), .WORDS_PER_MATRIX(W), .DATA_W(DW), .ADDR_W(AW)) u_dut1 (
        .clk(clk), .rst(rst), .go(go1), .rom_addr(addr1), .rom_rdata(rdata1),
        .start_out(start1), .valid_out(valid1), .x_out(x1),
        .finish_in(fin1), .busy(busy1), .done(done1));

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rom_rdata <= mem[rom_addr];
        rdata1    <= mem[addr1];
    end

    always @(negedge clk) begin
        if (start_out) start_q.push_back(cyc);
        if (valid_out) begin
            beat_c.push_back(cyc);
            beat_v.push_back(x_out);
        end
        if (done) done_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) step(1);
    endtask

    task automatic clear_mon();
        start_q.delete();
        beat_c.delete();
        beat_v.delete();
        done_q.delete();
    endtask

    // One full run; a finish pulse lands off[m] cycles after matrix m's start.
    // Model: the last issue is start+31, last beat start+33, pipe empty from start+34,
    // so the next start (or done) follows max(off, 34)+1 cycles after the start.
    task automatic do_run(input string name, input int off0, input int off1, input bit noise, input bit xgo);
        int offs[2];
        int exp_s, s, ok;
        offs = '{off0, off1};
        clear_mon();
        exp_s = cyc + 1;
        go = 1'b1;
        step(1);
        go = 1'b0;
        chk($sformatf("%s_busy_after_go", name), busy, 1);
        for (int m = 0; m < M; m++) begin
            ok = 0;
            for (int t = 0; t < 200 && ok == 0; t++) begin
                if (start_q.size() > m) ok = 1;
                else step(1);
            end
            if (ok == 0) begin
                chk($sformatf("%s_start%0d_timeout", name, m), 0, 1);
                return;
            end
            s = start_q[m];
            chk($sformatf("%s_start%0d_cyc", name, m), s, exp_s);
            if (noise) begin
                to_cyc(s + int'($urandom_range(3, 28)));
                finish_in = 1'b1;
                go = xgo;
                step(1);
                finish_in = 1'b0;
                go = 1'b0;
            end
            if (xgo) begin
                to_cyc(s + 33);
                go = 1'b1;
                step(1);
                go = 1'b0;
            end
            to_cyc(s + offs[m]);
            finish_in = 1'b1;
            step(1);
            finish_in = 1'b0;
            exp_s = s + ((offs[m] > 34) ? offs[m] : 34) + 1;
        end
        for (int t = 0; t < 100 && done_q.size() == 0; t++) step(1);
        step(4);
        chk($sformatf("%s_starts", name), start_q.size(), M);
        chk($sformatf("%s_dones", name), done_q.size(), 1);
        if (done_q.size() > 0) chk($sformatf("%s_done_cyc", name), done_q[0], exp_s);
        chk($sformatf("%s_beats", name), beat_v.size(), M * W);
        for (int k = 0; k < beat_v.size() && k < M * W; k++) begin
            chk($sformatf("%s_beat%0d_val", name, k), beat_v[k], mem[k]);
            if (start_q.size() > k / W)
                chk($sformatf("%s_beat%0d_cyc", name, k), beat_c[k], start_q[k / W] + 2 + k % W);
        end
        chk($sformatf("%s_busy_end", name), busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int s, o0, o1, ok, n_start, n_beat, n_done, d_cyc, b0_cyc;
        bit nz, xg;
        rst = 1'b0;
        go = 1'b0;
        finish_in = 1'b0;
        go1 = 1'b0;
        fin1 = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        #2;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_start", start_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_x", x_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_busy1", busy1, 0);
        step(2);
        rst = 1'b1;
        step(1);

        finish_in = 1'b1;
        step(2);
        finish_in = 1'b0;
        step(1);
        chk("idle_finish_ignored", busy, 0);

        do_run("basic", 40, 40, 1'b0, 1'b0);
        do_run("early", 32, 32, 1'b0, 1'b0);
        do_run("noise", 36, 33, 1'b1, 1'b0);
        do_run("gobusy", 35, 41, 1'b1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = DW'($urandom_range(0, 127));
            o0 = int'($urandom_range(32, 45));
            o1 = int'($urandom_range(32, 45));
            nz = 1'($urandom_range(0, 1));
            xg = (o0 >= 35 && o1 >= 35) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_run($sformatf("rand%0d", r), o0, o1, nz, xg);
        end

        clear_mon();
        go = 1'b1;
        step(1);
        go = 1'b0;
        ok = 0;
        for (int t = 0; t < 50 && ok == 0; t++) begin
            if (start_q.size() > 0) ok = 1;
            else step(1);
        end
        chk("mid_rst_start_seen", ok, 1);
        s = (ok != 0) ? start_q[0] : cyc;
        to_cyc(s + 12);
        chk("mid_rst_beats_before", beat_v.size(), 10);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_x", x_out, 0);
        chk("mid_rst_addr", rom_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", start_out, 0);
        clear_mon();
        step(3);
        rst = 1'b1;
        step(40);
        chk("mid_rst_no_beats", beat_v.size(), 0);
        chk("mid_rst_no_done", done_q.size(), 0);
        chk("mid_rst_no_restart", start_q.size(), 0);
        do_run("after_rst", 34, 37, 1'b0, 1'b0);

        n_start = 0;
        n_beat = 0;
        n_done = 0;
        d_cyc = -1;
        b0_cyc = -1;
        s = -1;
        go1 = 1'b1;
        step(1);
        go1 = 1'b0;
        for (int t = 0; t < 150; t++) begin
            if (start1) begin
                n_start++;
                s = cyc;
            end
            if (valid1) begin
                if (n_beat == 0) b0_cyc = cyc;
                if (n_beat < 64) chk($sformatf("m1_beat%0d", n_beat), x1, mem[n_beat]);
                n_beat++;
            end
            if (done1) begin
                n_done++;
                d_cyc = cyc;
            end
            fin1 = (s >= 0 && cyc == s + 36);
            step(1);
        end
        fin1 = 1'b0;
        chk("m1_starts", n_start, 1);
        chk("m1_beats", n_beat, W);
        chk("m1_dones", n_done, 1);
        chk("m1_first_beat_cyc", b0_cyc, s + 2);
        chk("m1_done_cyc", d_cyc, s + 37);
        chk("m1_busy_end", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
